pattern_fifo_writer: RTL and testbench

- Upstream data source for the read-path throughput test: generates a programmable 64-bit test pattern and pushes it into the 64-bit-write / 32-bit-read non-symmetric FIFO that drains to the host pipe-out.
- Started by a trigger from the host; runs for a host-programmed word count.
- Honours FIFO backpressure and reports progress and completion for the host-side checker and timer.

---
 rtl/pattern_fifo_writer.sv | 130 +++++++++++++
 tb/tb_pattern_fifo_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_fifo_writer.sv
// Pattern source for the read-path throughput test: writes word_count 64-bit pattern words into the
// 64w/32r FIFO at one word per clock while not full; abort ends a run early, status is polled by the host.
module pattern_fifo_writer #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter int          CNT_W     = 32
) (
  input  logic             okClk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       pattern_sel,
  input  logic [CNT_W-1:0] word_count,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [63:0]      fifo_din,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ww_q;
  logic [63:0]      din_q;
  logic [31:0]      lfsr_q;
  logic [31:0]      n_q;
  logic             busy_q, done_q, aborted_q;

  logic [31:0]      lfsr_d;
  logic [31:0]      n_d;
  logic [CNT_W-1:0] ww_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // n is the half index of the upper half; the lower half is always n+1.
  function automatic logic [63:0] gen_word(input logic [1:0] sel, input logic [31:0] n,
                                           input logic [31:0] s);
    logic [31:0] n1;
    n1 = n + 32'd1;
    case (sel)
      2'd0:    return {n, n1};
      2'd1:    return {32'd1 << n[4:0], 32'd1 << n1[4:0]};
      2'd2:    return {s, lfsr_step(s)};
      default: return {32'hAAAA_AAAA, 32'h5555_5555};
    endcase
  endfunction

  // Including reset_n keeps a write from being issued on the edge that discards the run.
  assign fifo_wr_en = reset_n & (state_q == RUN) & ~fifo_full & ~abort;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_step(lfsr_q));
    n_d    = n_q + 32'd2;
    ww_d   = ww_q + CNT_W'(1);
  end

  always_ff @(posedge okClk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      cnt_q     <= '0;
      ww_q      <= '0;
      din_q     <= 64'd0;
      lfsr_q    <= LFSR_SEED;
      n_q       <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start && !abort) begin
            sel_q     <= pattern_sel;
            cnt_q     <= word_count;
            ww_q      <= '0;
            aborted_q <= 1'b0;
            din_q     <= gen_word(pattern_sel, 32'd0, LFSR_SEED);
            lfsr_q    <= LFSR_SEED;
            n_q       <= 32'd0;
            if (word_count == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (fifo_wr_en && ww_q != cnt_q) begin
            ww_q   <= ww_d;
            n_q    <= n_d;
            lfsr_q <= lfsr_d;
            din_q  <= gen_word(sel_q, n_d, lfsr_d);
            if (ww_d == cnt_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_din      = din_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_pattern_fifo_writer.sv
// Scoreboard bench for pattern_fifo_writer: expected words are queued at start, popped per FIFO write.
module tb_pattern_fifo_writer;

  logic        okClk = 1'b0;
  logic        reset_n, start, abort, fifo_full;
  logic [1:0]  pattern_sel;
  logic [31:0] word_count;
  logic        fifo_wr_en, busy, done, aborted;
  logic [63:0] fifo_din;
  logic [31:0] words_written;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cap_q[$];

  pattern_fifo_writer dut (
    .okClk(okClk), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .word_count(word_count), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy), .done(done),
    .aborted(aborted), .words_written(words_written)
  );

  always #5 okClk = ~okClk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: every half is derived from its index alone.
  function automatic logic [31:0] m_half(input int sel, input int unsigned n);
    logic [31:0] s;
    case (sel)
      0: return n;
      1: return 32'h1 << (n % 32);
      2: begin
        s = 32'hACE1_2468;
        for (int unsigned i = 0; i < n; i++) s = {s[30:0], ^(s & 32'h8020_0003)};
        return s;
      end
      default: return (n % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
  endfunction

  function automatic logic [63:0] m_word(input int sel, input int unsigned k);
    return {m_half(sel, 2 * k), m_half(sel, 2 * k + 1)};
  endfunction

  always @(negedge okClk) begin
    if (fifo_wr_en) begin
      chk("wr_while_full", {63'd0, fifo_full}, 64'd0);
      if (exp_q.size() == 0) chk("unexpected_wr", 64'd1, 64'd0);
      else chk("data", fifo_din, exp_q.pop_front());
      cap_q.push_back(fifo_din);
      wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic run(input int sel, input int unsigned cnt);
    for (int unsigned k = 0; k < cnt; k++) exp_q.push_back(m_word(sel, k));
    cap_q.delete();
    wr_cnt      = 0;
    pattern_sel = 2'(sel);
    word_count  = cnt;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (!done && edges < budget) begin
      tick();
      edges++;
    end
    if (!done) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_aborted"}, {63'd0, aborted}, 64'd0);
    chk({tag, "_ww"}, {32'd0, words_written}, 64'd0);
    chk({tag, "_din"}, fifo_din, 64'd0);
    chk({tag, "_wr_en"}, {63'd0, fifo_wr_en}, 64'd0);
  endtask

  initial begin
    int edges;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    pattern_sel = 2'd0; word_count = 32'd0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Counter, 4 words
    run(0, 4);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    wait_done(20, edges);
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_ww", {32'd0, words_written}, 64'd4);
    chk("t1_aborted", {63'd0, aborted}, 64'd0);
    chk("t1_wrcnt", 64'(wr_cnt), 64'd4);
    chk("t1_w3", cap_q[3], 64'h00000006_00000007);

    // Walking one, 18 words
    run(1, 18);
    wait_done(40, edges);
    chk("t2_ww", {32'd0, words_written}, 64'd18);
    chk("t2_w0", cap_q[0], 64'h00000001_00000002);
    chk("t2_w15", cap_q[15], 64'h40000000_80000000);
    chk("t2_w16", cap_q[16], 64'h00000001_00000002);

    // Counter with 3 stall cycles after the second write
    run(0, 8);
    tick();
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_din", fifo_din, 64'h00000004_00000005);
      chk("t3_no_wr", {63'd0, fifo_wr_en}, 64'd0);
      tick();
    end
    fifo_full = 1'b0;
    wait_done(20, edges);
    chk("t3_cycles", 64'(5 + edges), 64'd11);
    chk("t3_wrcnt", 64'(wr_cnt), 64'd8);
    chk("t3_ww", {32'd0, words_written}, 64'd8);

    // LFSR, 3 words
    run(2, 3);
    wait_done(20, edges);
    chk("t4_w0_upper", {32'd0, cap_q[0][63:32]}, 64'hACE12468);
    chk("t4_ww", {32'd0, words_written}, 64'd3);

    // Fixed, abort after 10 writes; start during RUN ignored
    run(3, 100);
    repeat (3) tick();
    pattern_sel = 2'd0;
    word_count  = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    #1;
    chk("t5_abort_no_wr", {63'd0, fifo_wr_en}, 64'd0);
    tick();
    abort = 1'b0;
    chk("t5_done", {63'd0, done}, 64'd1);
    chk("t5_aborted", {63'd0, aborted}, 64'd1);
    chk("t5_ww", {32'd0, words_written}, 64'd10);
    chk("t5_left", 64'(exp_q.size()), 64'd90);
    exp_q.delete();
    run(3, 2);
    chk("t5_aborted_clr", {63'd0, aborted}, 64'd0);
    wait_done(20, edges);
    chk("t5_restart_w0", cap_q[0], 64'hAAAAAAAA_55555555);

    // Reset mid-run
    run(0, 50);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("t6_wr_en_rst", {63'd0, fifo_wr_en}, 64'd0);
    tick();
    chk_reset_vals("t6");
    reset_n = 1'b1;
    exp_q.delete();
    tick();

    // Zero-length run from IDLE
    chk("t7_pre_done", {63'd0, done}, 64'd0);
    run(0, 0);
    chk("t7_done", {63'd0, done}, 64'd1);
    chk("t7_busy", {63'd0, busy}, 64'd0);
    repeat (3) tick();
    chk("t7_wrcnt", 64'(wr_cnt), 64'd0);

    // start+abort together in IDLE
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    wr_cnt = 0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t8_busy", {63'd0, busy}, 64'd0);
    chk("t8_done", {63'd0, done}, 64'd0);
    repeat (2) tick();
    chk("t8_wrcnt", 64'(wr_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
